// File: rtl/dm_vec_sequencer.sv
// ---------------------------------------------------------------------------
// dm_vec_sequencer
//   Owns the single data-memory port and executes D[i] = A[i] op B[i] for
//   i = 0..len-1 from a single start pulse. Each element costs three cycles:
//   read A, read B, write D. The memory read is combinational, so each read
//   state captures dm_dat_out on its exiting edge.
//
// Ports
//   clk          system clock, all state on posedge
//   reset        asynchronous, active-low reset
//   start        command strobe, only honoured in IDLE
//   op           0=XOR 1=AND 2=OR 3=ADD (mod 2^DW)
//   a_base       first address of operand vector A
//   b_base       first address of operand vector B
//   d_base       first address of destination vector D
//   len          element count, 0..255
//   dm_addr      memory address
//   dm_wr_en     memory write enable (WR state only)
//   dm_dat_in    memory write data (0 outside WR)
//   dm_dat_out   memory read data
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   carry        sticky ADD carry-out over the whole command
//
// State table
//   IDLE  | waiting for start
//   RD_A  | address A[i], capture operand a
//   RD_B  | address B[i], capture operand b
//   WR    | write D[i] = a op b, advance index
//   DONE  | one-cycle completion pulse, still busy
// ---------------------------------------------------------------------------
module dm_vec_sequencer #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] d_base,
    input  logic [7:0]    len,
    output logic [AW-1:0] dm_addr,
    output logic          dm_wr_en,
    output logic [DW-1:0] dm_dat_in,
    input  logic [DW-1:0] dm_dat_out,
    output logic          busy,
    output logic          done,
    output logic          carry
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_XOR = 2'd0;
    localparam logic [1:0] OP_AND = 2'd1;
    localparam logic [1:0] OP_OR  = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [1:0]      r_op;
    logic [AW-1:0]   r_a_base;
    logic [AW-1:0]   r_b_base;
    logic [AW-1:0]   r_d_base;
    logic [7:0]      r_len;
    logic [7:0]      r_idx;
    logic [DW-1:0]   r_ra;
    logic [DW-1:0]   r_rb;
    logic            r_carry;

    logic            w_accept;
    logic            w_last;
    logic [AW-1:0]   w_idx_aw;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_result;

    assign w_accept = (r_state == S_IDLE) && start;
    // len <= 255 keeps r_idx <= 254 here, so the 8-bit increment cannot wrap
    assign w_last   = ((r_idx + 8'd1) == r_len);
    assign w_idx_aw = AW'(r_idx);
    assign w_sum    = {1'b0, r_ra} + {1'b0, r_rb};

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_XOR:  w_result = r_ra ^ r_rb;
            OP_AND:  w_result = r_ra & r_rb;
            OP_OR:   w_result = r_ra | r_rb;
            OP_ADD:  w_result = w_sum[DW-1:0];
            default: w_result = '0;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                // len is taken from the port here: it is latched on this same edge
                if (start) begin
                    w_state_nxt = (len == 8'd0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  w_state_nxt = S_RD_B;
            S_RD_B:  w_state_nxt = S_WR;
            S_WR:    w_state_nxt = w_last ? S_DONE : S_RD_A;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_a_base <= '0;
            r_b_base <= '0;
            r_d_base <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_ra     <= '0;
            r_rb     <= '0;
            r_carry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op     <= op;
                r_a_base <= a_base;
                r_b_base <= b_base;
                r_d_base <= d_base;
                r_len    <= len;
                r_idx    <= '0;
                r_carry  <= 1'b0;
            end
            if (r_state == S_RD_A) begin
                r_ra <= dm_dat_out;
            end
            if (r_state == S_RD_B) begin
                r_rb <= dm_dat_out;
            end
            if (r_state == S_WR) begin
                r_idx <= r_idx + 8'd1;
                if (r_op == OP_ADD) begin
                    r_carry <= r_carry | w_sum[DW];
                end
            end
        end
    end

    // ---------------- output decode ----------------
    // Everything below depends on registers only, so a reset drops the
    // write enable asynchronously and no in-flight write can commit.
    always_comb begin
        dm_addr   = '0;
        dm_wr_en  = 1'b0;
        dm_dat_in = '0;
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        carry     = r_carry;
        case (r_state)
            S_RD_A: dm_addr = r_a_base + w_idx_aw;
            S_RD_B: dm_addr = r_b_base + w_idx_aw;
            S_WR: begin
                dm_addr   = r_d_base + w_idx_aw;
                dm_wr_en  = 1'b1;
                dm_dat_in = w_result;
            end
            default: dm_addr = '0;
        endcase
    end

endmodule

// File: tb/tb_dm_vec_sequencer.sv
module tb_dm_vec_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a_base;
    logic [7:0] b_base;
    logic [7:0] d_base;
    logic [7:0] len;
    logic [7:0] dm_addr;
    logic       dm_wr_en;
    logic [7:0] dm_dat_in;
    logic [7:0] dm_dat_out;
    logic       busy;
    logic       done;
    logic       carry;

    logic [7:0] mem [0:255];
    logic       pk_en;
    logic [7:0] pk_addr;
    logic [7:0] pk_data;

    int n_cmp;
    int n_err;
    logic [7:0] addr_q[$];

    dm_vec_sequencer #(.DW(8), .AW(8)) u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .op         (op),
        .a_base     (a_base),
        .b_base     (b_base),
        .d_base     (d_base),
        .len        (len),
        .dm_addr    (dm_addr),
        .dm_wr_en   (dm_wr_en),
        .dm_dat_in  (dm_dat_in),
        .dm_dat_out (dm_dat_out),
        .busy       (busy),
        .done       (done),
        .carry      (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: combinational read, write on posedge; pokes preload it
    assign dm_dat_out = mem[dm_addr];
    always @(posedge clk) begin
        if (dm_wr_en) mem[dm_addr] <= dm_dat_in;
        else if (pk_en) mem[pk_addr] <= pk_data;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pk_en = 1'b1; pk_addr = a; pk_data = d;
        @(negedge clk);
        pk_en = 1'b0;
    endtask

    // issues one command; k counts cycles with the start edge's cycle as 1
    task automatic run_cmd(input logic [1:0] op_v, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] d, input logic [7:0] l, input bit hold,
                           output int done_edge, output int n_wr, output int n_busy,
                           output int n_done);
        done_edge = -1; n_wr = 0; n_busy = 0; n_done = 0;
        addr_q.delete();
        @(negedge clk);
        op = op_v; a_base = a; b_base = b; d_base = d; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        // scramble inputs: the running command must ignore them
        op = ~op_v; a_base = ~a; b_base = ~b; d_base = ~d; len = l + 8'd5;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            if (busy) n_busy++;
            if (dm_wr_en) n_wr++;
            if (busy && !done) addr_q.push_back(dm_addr);
            if (done) begin
                n_done++;
                done_edge = k;
                start = 1'b0;
                break;
            end
            @(posedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        if (busy) n_busy++;
        if (done) n_done++;
        if (dm_wr_en) n_wr++;
    endtask

    initial begin
        int de, nw, nb, nd;
        logic [7:0] exp_addr [9];
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0; op = '0;
        a_base = '0; b_base = '0; d_base = '0; len = '0;
        pk_en = 1'b0; pk_addr = '0; pk_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_wr_en", dm_wr_en, 0);
        check_val("rst_addr", dm_addr, 0);
        check_val("rst_dat_in", dm_dat_in, 0);
        check_val("rst_carry", carry, 0);
        rst_n = 1'b1;

        // XOR, len 1
        poke(8'h00, 8'h5A); poke(8'h01, 8'h0F);
        run_cmd(2'd0, 8'h00, 8'h01, 8'h02, 8'd1, 1'b0, de, nw, nb, nd);
        check_val("xor_mem2", mem[2], 8'h55);
        check_val("xor_writes", nw, 1);
        check_val("xor_done_edge", de, 4);
        check_val("xor_done_cycles", nd, 1);
        check_val("xor_busy_cycles", nb, 4);

        // AND, len 1
        poke(8'h03, 8'hF0); poke(8'h04, 8'h3C);
        run_cmd(2'd1, 8'h03, 8'h04, 8'h05, 8'd1, 1'b0, de, nw, nb, nd);
        check_val("and_mem5", mem[5], 8'h30);
        check_val("and_mem0", mem[0], 8'h5A);
        check_val("and_mem1", mem[1], 8'h0F);
        check_val("and_mem2", mem[2], 8'h55);
        check_val("and_mem3", mem[3], 8'hF0);
        check_val("and_mem4", mem[4], 8'h3C);
        check_val("and_carry", carry, 0);

        // ADD, len 3, A wraps through 0xFF -> 0x00
        poke(8'hFE, 8'h80); poke(8'hFF, 8'h01); poke(8'h00, 8'hFF);
        poke(8'h10, 8'h80); poke(8'h11, 8'h02); poke(8'h12, 8'h01);
        run_cmd(2'd3, 8'hFE, 8'h10, 8'h20, 8'd3, 1'b0, de, nw, nb, nd);
        check_val("add_mem20", mem[8'h20], 8'h00);
        check_val("add_mem21", mem[8'h21], 8'h03);
        check_val("add_mem22", mem[8'h22], 8'h00);
        check_val("add_carry", carry, 1);
        check_val("add_done_edge", de, 10);
        check_val("add_writes", nw, 3);
        exp_addr = '{8'hFE, 8'h10, 8'h20, 8'hFF, 8'h11, 8'h21, 8'h00, 8'h12, 8'h22};
        check_val("add_addr_count", addr_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check_val($sformatf("add_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 8'hXX, exp_addr[i]);
        end

        // len 0: immediate done, no write, carry cleared by the new start
        run_cmd(2'd3, 8'h00, 8'h01, 8'h02, 8'd0, 1'b0, de, nw, nb, nd);
        check_val("len0_done_edge", de, 1);
        check_val("len0_writes", nw, 0);
        check_val("len0_busy_cycles", nb, 1);
        check_val("len0_carry", carry, 0);
        check_val("len0_mem2", mem[2], 8'h55);

        // start held high through a len 2 command
        poke(8'h30, 8'h11); poke(8'h31, 8'h22); poke(8'h32, 8'h0F); poke(8'h33, 8'hF0);
        run_cmd(2'd0, 8'h30, 8'h32, 8'h40, 8'd2, 1'b1, de, nw, nb, nd);
        check_val("hold_writes", nw, 2);
        check_val("hold_done_edge", de, 7);
        check_val("hold_busy_cycles", nb, 7);
        check_val("hold_mem40", mem[8'h40], 8'h1E);
        check_val("hold_mem41", mem[8'h41], 8'hD2);
        run_cmd(2'd2, 8'h30, 8'h31, 8'h42, 8'd1, 1'b0, de, nw, nb, nd);
        check_val("fresh_done_edge", de, 4);
        check_val("fresh_mem42", mem[8'h42], 8'h33);

        // reset during the second RD_B of a len 4 OR command
        poke(8'h50, 8'h01); poke(8'h51, 8'h02); poke(8'h52, 8'h04); poke(8'h53, 8'h08);
        poke(8'h60, 8'h10); poke(8'h61, 8'h20); poke(8'h62, 8'h40); poke(8'h63, 8'h80);
        poke(8'h70, 8'hAA); poke(8'h71, 8'hAA); poke(8'h72, 8'hAA); poke(8'h73, 8'hAA);
        @(negedge clk);
        op = 2'd2; a_base = 8'h50; b_base = 8'h60; d_base = 8'h70; len = 8'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_val("rstmid_pre_addr", dm_addr, 8'h61);
        check_val("rstmid_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_busy", busy, 0);
        check_val("rstmid_addr", dm_addr, 0);
        check_val("rstmid_wr_en", dm_wr_en, 0);
        check_val("rstmid_dat_in", dm_dat_in, 0);
        check_val("rstmid_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("rstmid_busy_after", busy, 0);
        check_val("rstmid_mem70", mem[8'h70], 8'h11);
        check_val("rstmid_mem71", mem[8'h71], 8'hAA);
        check_val("rstmid_mem72", mem[8'h72], 8'hAA);
        check_val("rstmid_mem73", mem[8'h73], 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
